// File: rtl/phys_reg_file_mp.sv
`default_nettype none
// ============================================================================
// phys_reg_file_mp : multi-ported physical register file with ready bits,
// CDB bypass on reads, pending count and flush recovery.        Rev 1.0
// ============================================================================
module phys_reg_file_mp #(
    parameter  int NUM_PREGS = 64,
    parameter  int DATA_W    = 32,
    parameter  int NUM_RD    = 4,
    parameter  int NUM_WR    = 2,
    parameter  int NUM_ALLOC = 2,
    localparam int PW        = $clog2(NUM_PREGS)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic [NUM_ALLOC-1:0]                alloc_valid,
    input  logic [NUM_ALLOC-1:0][PW-1:0]        alloc_preg,
    input  logic [NUM_WR-1:0]                   cdb_valid,
    input  logic [NUM_WR-1:0][PW-1:0]           cdb_preg,
    input  logic [NUM_WR-1:0][DATA_W-1:0]       cdb_data,
    input  logic [NUM_RD-1:0][PW-1:0]           rd_preg,
    output logic [NUM_RD-1:0][DATA_W-1:0]       rd_data,
    output logic [NUM_RD-1:0]                   rd_ready,
    output logic [PW:0]                         pending_cnt,
    output logic                                wr_conflict
);

    logic [DATA_W-1:0]    r_data [NUM_PREGS];
    logic [NUM_PREGS-1:0] r_ready;
    logic [PW:0]          r_cnt;
    logic                 r_conflict;

    logic [NUM_PREGS-1:0] w_ready_nxt;
    logic [PW:0]          w_cnt_nxt;
    logic                 w_conflict;

    // Ready update priority: CDB sets, alloc clears, flush restores everything.
    always_comb begin
        w_ready_nxt = r_ready;
        for (int i = 0; i < NUM_WR; i++) begin
            if (cdb_valid[i] && cdb_preg[i] != '0)
                w_ready_nxt[cdb_preg[i]] = 1'b1;
        end
        for (int j = 0; j < NUM_ALLOC; j++) begin
            if (alloc_valid[j] && alloc_preg[j] != '0)
                w_ready_nxt[alloc_preg[j]] = 1'b0;
        end
        if (flush)
            w_ready_nxt = '1;
        w_ready_nxt[0] = 1'b1;
    end

    // Counting the next ready vector directly keeps the count exact and
    // handles duplicate allocs without special cases.
    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 0; i < NUM_PREGS; i++)
            w_cnt_nxt = w_cnt_nxt + {{PW{1'b0}}, ~w_ready_nxt[i]};
    end

    always_comb begin
        w_conflict = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (cdb_valid[i] && cdb_valid[j] && cdb_preg[i] == cdb_preg[j] &&
                    cdb_preg[i] != '0)
                    w_conflict = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready    <= '1;
            r_cnt      <= '0;
            r_conflict <= 1'b0;
        end else begin
            r_ready    <= w_ready_nxt;
            r_cnt      <= w_cnt_nxt;
            r_conflict <= r_conflict | w_conflict;
        end
    end

    // Descending port order so the lowest-index port's write lands last.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NUM_PREGS; p++)
                r_data[p] <= '0;
        end else begin
            for (int i = NUM_WR - 1; i >= 0; i--) begin
                if (cdb_valid[i] && cdb_preg[i] != '0)
                    r_data[cdb_preg[i]] <= cdb_data[i];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            rd_data[k]  = r_data[rd_preg[k]];
            rd_ready[k] = r_ready[rd_preg[k]];
            for (int i = NUM_WR - 1; i >= 0; i--) begin
                if (cdb_valid[i] && cdb_preg[i] == rd_preg[k]) begin
                    rd_data[k]  = cdb_data[i];
                    rd_ready[k] = 1'b1;
                end
            end
            if (rd_preg[k] == '0) begin
                rd_data[k]  = '0;
                rd_ready[k] = 1'b1;
            end
        end
    end

    assign pending_cnt = r_cnt;
    assign wr_conflict = r_conflict;

endmodule
`default_nettype wire
